// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch program-counter sequencer with stall, redirect and bubble handling
//
// Purpose:
//   Owns the registered fetch address. Each cycle it picks the next PC from
//   four sources: sequential (pc+4), a resolved branch, a jump, or the
//   exception vector. The priority is exception > jump > branch > sequential.
//   A redirect kills the younger in-flight fetch (flush) and enters a
//   one-cycle BUBBLE. A branch or jump that arrives while decode is stalled
//   is parked in a one-entry pending register and replayed when the stall
//   releases.
//
// Build option:
//   PC_FETCH_CTRL_EXC_EN - when defined, exception redirects to EXC_VECTOR
//                          (pc_sel = 3). When undefined, exception is ignored
//                          and pc_sel never reaches 3.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   stall               - hazard hold request from decode
//   branch_taken/target - resolved taken branch and its destination
//   jump/jump_target    - jump request and its destination
//   exception           - one-cycle exception pulse
//   pc                  - registered fetch address
//   pc_sel              - next-PC mux select (0 seq, 1 branch, 2 jump, 3 exc)
//   fetch_valid         - current pc is a valid fetch
//   flush               - kill the younger fetch, same cycle as the redirect
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic [31:0] pc,
    output logic [1:0]  pc_sel,
    output logic        fetch_valid,
    output logic        flush
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;
    localparam logic [1:0] SEL_EXC    = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_sel_q, pend_sel_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        exc_req;
    logic [31:0] pc_plus4;
    logic        req_valid;
    logic [1:0]  req_sel;
    logic [31:0] req_target;
    logic        cap_valid;
    logic [1:0]  cap_sel;
    logic [31:0] cap_target;

`ifdef PC_FETCH_CTRL_EXC_EN
    assign exc_req = exception;
`else
    logic unused_exc;
    assign exc_req    = 1'b0;
    assign unused_exc = exception ^ (^EXC_VECTOR);
`endif

    // Wraps naturally modulo 2^32.
    assign pc_plus4 = pc_q + 32'd4;

    // Same-cycle request arbitration: jump beats branch.
    always_comb begin
        req_valid  = 1'b0;
        req_sel    = SEL_SEQ;
        req_target = 32'h0;
        if (jump) begin
            req_valid  = 1'b1;
            req_sel    = SEL_JUMP;
            req_target = jump_target;
        end else if (branch_taken) begin
            req_valid  = 1'b1;
            req_sel    = SEL_BRANCH;
            req_target = branch_target;
        end
    end

    // Pending entry as it would look after this cycle's capture. A jump always
    // overwrites; a branch never displaces an already-parked jump.
    always_comb begin
        cap_valid  = pend_valid_q;
        cap_sel    = pend_sel_q;
        cap_target = pend_target_q;
        if (jump) begin
            cap_valid  = 1'b1;
            cap_sel    = SEL_JUMP;
            cap_target = jump_target;
        end else if (branch_taken && !(pend_valid_q && pend_sel_q == SEL_JUMP)) begin
            cap_valid  = 1'b1;
            cap_sel    = SEL_BRANCH;
            cap_target = branch_target;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_sel_d    = pend_sel_q;
        pend_target_d = pend_target_q;
        pc_sel        = SEL_SEQ;
        flush         = 1'b0;
        fetch_valid   = (state_q != ST_STALL);

        if (reset) begin
            fetch_valid = 1'b0;
        end else if (exc_req) begin
            pc_sel       = SEL_EXC;
            pc_d         = {EXC_VECTOR[31:2], 2'b00};
            flush        = 1'b1;
            state_d      = ST_BUBBLE;
            pend_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (req_valid) begin
                        pc_sel  = req_sel;
                        pc_d    = {req_target[31:2], 2'b00};
                        flush   = 1'b1;
                        state_d = ST_BUBBLE;
                    end else if (stall) begin
                        state_d = ST_STALL;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                ST_STALL: begin
                    if (stall) begin
                        pend_valid_d  = cap_valid;
                        pend_sel_d    = cap_sel;
                        pend_target_d = cap_target;
                    end else if (cap_valid) begin
                        pc_sel       = cap_sel;
                        pc_d         = {cap_target[31:2], 2'b00};
                        flush        = 1'b1;
                        state_d      = ST_BUBBLE;
                        pend_valid_d = 1'b0;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = ST_RUN;
                    end
                end
                ST_BUBBLE: begin
                    // Requests here come from the wrong path and are dropped.
                    if (stall) begin
                        state_d = ST_STALL;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_sel_q    <= SEL_SEQ;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_sel_q    <= pend_sel_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        exception = 1'b0;
    logic [31:0] pc;
    logic [1:0]  pc_sel;
    logic        fetch_valid;
    logic        flush;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exception(exception),
        .pc(pc), .pc_sel(pc_sel), .fetch_valid(fetch_valid), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r;
        logic        s;
        logic        b;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        e;
        logic [1:0]  sel;
        logic        fl;
        logic        fv;
        logic [31:0] nxt;
    } cyc_t;

    function automatic cyc_t mk(input logic r, input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic e,
                                input logic [1:0] sel, input logic fl, input logic fv,
                                input logic [31:0] nxt);
        cyc_t c;
        c.r = r; c.s = s; c.b = b; c.bt = bt; c.j = j; c.jt = jt; c.e = e;
        c.sel = sel; c.fl = fl; c.fv = fv; c.nxt = nxt;
        return c;
    endfunction

    // Applies one cycle of stimulus and queues the pc expected after the edge.
    task automatic drive(input cyc_t c);
        reset = c.r; stall = c.s; branch_taken = c.b; branch_target = c.bt;
        jump = c.j; jump_target = c.jt; exception = c.e;
        exp_q.push_back(c.nxt);
        #1;
    endtask

    task automatic test_reset();
        cyc_t t[$];
        logic [31:0] e;
        t.push_back(mk(1, 1, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4));
        foreach (t[i]) begin
            drive(t[i]);
            total++; if (pc_sel !== t[i].sel) begin bad++; $display("FAIL reset_sel[%0d] got %0d want %0d", i, pc_sel, t[i].sel); end
            total++; if (flush !== t[i].fl) begin bad++; $display("FAIL reset_flush[%0d] got %0b want %0b", i, flush, t[i].fl); end
            total++; if (fetch_valid !== t[i].fv) begin bad++; $display("FAIL reset_fv[%0d] got %0b want %0b", i, fetch_valid, t[i].fv); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL reset_pc[%0d] got %h want %h", i, pc, e); end
        end
    endtask

    task automatic test_sequential();
        cyc_t t[$];
        logic [31:0] e;
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        for (int k = 1; k <= 4; k++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(k * 4)));
        foreach (t[i]) begin
            drive(t[i]);
            total++; if (pc_sel !== t[i].sel) begin bad++; $display("FAIL seq_sel[%0d] got %0d want %0d", i, pc_sel, t[i].sel); end
            total++; if (flush !== t[i].fl) begin bad++; $display("FAIL seq_flush[%0d] got %0b want %0b", i, flush, t[i].fl); end
            total++; if (fetch_valid !== t[i].fv) begin bad++; $display("FAIL seq_fv[%0d] got %0b want %0b", i, fetch_valid, t[i].fv); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, e); end
        end
    endtask

    task automatic test_branch();
        cyc_t t[$];
        logic [31:0] e;
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8));
        t.push_back(mk(0, 0, 1, 32'h100, 0, 0, 0, 1, 1, 1, 32'h100));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h108));
        foreach (t[i]) begin
            drive(t[i]);
            total++; if (pc_sel !== t[i].sel) begin bad++; $display("FAIL branch_sel[%0d] got %0d want %0d", i, pc_sel, t[i].sel); end
            total++; if (flush !== t[i].fl) begin bad++; $display("FAIL branch_flush[%0d] got %0b want %0b", i, flush, t[i].fl); end
            total++; if (fetch_valid !== t[i].fv) begin bad++; $display("FAIL branch_fv[%0d] got %0b want %0b", i, fetch_valid, t[i].fv); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL branch_pc[%0d] got %h want %h", i, pc, e); end
        end
    endtask

    task automatic test_stall();
        cyc_t t[$];
        logic [31:0] e;
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        for (int k = 1; k <= 4; k++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(k * 4)));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'd16));
        t.push_back(mk(0, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0, 32'd16));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd16));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 32'h200));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h204));
        foreach (t[i]) begin
            drive(t[i]);
            total++; if (pc_sel !== t[i].sel) begin bad++; $display("FAIL stall_sel[%0d] got %0d want %0d", i, pc_sel, t[i].sel); end
            total++; if (flush !== t[i].fl) begin bad++; $display("FAIL stall_flush[%0d] got %0b want %0b", i, flush, t[i].fl); end
            total++; if (fetch_valid !== t[i].fv) begin bad++; $display("FAIL stall_fv[%0d] got %0b want %0b", i, fetch_valid, t[i].fv); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL stall_pc[%0d] got %h want %h", i, pc, e); end
        end
    endtask

    task automatic test_bubble();
        cyc_t t[$];
        logic [31:0] e;
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 0, 0, 0, 1, 32'h40, 0, 2, 1, 1, 32'h40));
        t.push_back(mk(0, 0, 1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h44));
        t.push_back(mk(0, 0, 0, 0, 1, 32'h80, 0, 2, 1, 1, 32'h80));
`ifdef PC_FETCH_CTRL_EXC_EN
        t.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 1, 1, 32'h8000_0180));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0184));
`else
        t.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 32'h80));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h84));
`endif
        foreach (t[i]) begin
            drive(t[i]);
            total++; if (pc_sel !== t[i].sel) begin bad++; $display("FAIL bubble_sel[%0d] got %0d want %0d", i, pc_sel, t[i].sel); end
            total++; if (flush !== t[i].fl) begin bad++; $display("FAIL bubble_flush[%0d] got %0b want %0b", i, flush, t[i].fl); end
            total++; if (fetch_valid !== t[i].fv) begin bad++; $display("FAIL bubble_fv[%0d] got %0b want %0b", i, fetch_valid, t[i].fv); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL bubble_pc[%0d] got %h want %h", i, pc, e); end
        end
    endtask

    task automatic test_wrap_align();
        cyc_t t[$];
        logic [31:0] e;
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 2, 1, 1, 32'hFFFF_FFFC));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0));
        t.push_back(mk(0, 0, 0, 0, 1, 32'h203, 0, 2, 1, 1, 32'h200));
        t.push_back(mk(0, 0, 1, 32'h107, 0, 0, 0, 0, 0, 1, 32'h204));
        t.push_back(mk(0, 0, 1, 32'h107, 0, 0, 0, 1, 1, 1, 32'h104));
        foreach (t[i]) begin
            drive(t[i]);
            total++; if (pc_sel !== t[i].sel) begin bad++; $display("FAIL wrap_sel[%0d] got %0d want %0d", i, pc_sel, t[i].sel); end
            total++; if (flush !== t[i].fl) begin bad++; $display("FAIL wrap_flush[%0d] got %0b want %0b", i, flush, t[i].fl); end
            total++; if (fetch_valid !== t[i].fv) begin bad++; $display("FAIL wrap_fv[%0d] got %0b want %0b", i, fetch_valid, t[i].fv); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL wrap_pc[%0d] got %h want %h", i, pc, e); end
        end
    endtask

    task automatic test_reset_pending();
        cyc_t t[$];
        logic [31:0] e;
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8));
        t.push_back(mk(0, 1, 1, 32'h500, 0, 0, 0, 0, 0, 0, 32'h8));
        t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8));
        foreach (t[i]) begin
            drive(t[i]);
            total++; if (pc_sel !== t[i].sel) begin bad++; $display("FAIL rstpend_sel[%0d] got %0d want %0d", i, pc_sel, t[i].sel); end
            total++; if (flush !== t[i].fl) begin bad++; $display("FAIL rstpend_flush[%0d] got %0b want %0b", i, flush, t[i].fl); end
            total++; if (fetch_valid !== t[i].fv) begin bad++; $display("FAIL rstpend_fv[%0d] got %0b want %0b", i, fetch_valid, t[i].fv); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL rstpend_pc[%0d] got %h want %h", i, pc, e); end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t t[$];
        logic [31:0] e;
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0));
        t.push_back(mk(0, 1, 1, 32'h600, 0, 0, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 1, 0, 0, 1, 32'h700, 0, 0, 0, 0, 32'h0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 32'h700));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h700));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h704));
        t.push_back(mk(0, 0, 1, 32'h800, 0, 0, 0, 1, 1, 1, 32'h800));
        t.push_back(mk(0, 0, 0, 0, 1, 32'h900, 0, 0, 0, 1, 32'h804));
        t.push_back(mk(0, 0, 1, 32'hA00, 1, 32'hB00, 0, 2, 1, 1, 32'hB00));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB04));
        foreach (t[i]) begin
            drive(t[i]);
            total++; if (pc_sel !== t[i].sel) begin bad++; $display("FAIL b2b_sel[%0d] got %0d want %0d", i, pc_sel, t[i].sel); end
            total++; if (flush !== t[i].fl) begin bad++; $display("FAIL b2b_flush[%0d] got %0b want %0b", i, flush, t[i].fl); end
            total++; if (fetch_valid !== t[i].fv) begin bad++; $display("FAIL b2b_fv[%0d] got %0b want %0b", i, fetch_valid, t[i].fv); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++; if (pc !== e) begin bad++; $display("FAIL b2b_pc[%0d] got %h want %h", i, pc, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_bubble();
        test_wrap_align();
        test_reset_pending();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h80000180, exception handler address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold request from decode.
REQ-006 branch_taken  input  1  resolved taken branch this cycle.
REQ-007 branch_target  input  32  branch destination.
REQ-008 jump  input  1  jump request this cycle.
REQ-009 jump_target  input  32  jump destination.
REQ-010 exception  input  1  exception request, one-cycle pulse.
REQ-011 pc  output  32  registered fetch address.
REQ-012 pc_sel  output  2  select for the downstream 4-way next-PC mux: 0 = PC+4, 1 = branch, 2 = jump, 3 = exception vector.
REQ-013 fetch_valid  output  1  the current pc is a valid fetch.
REQ-014 flush  output  1  kill the younger in-flight fetch; combinational, same cycle as the redirect.

Function
REQ-015 The block SHALL implement FSM states RUN, STALL and BUBBLE.
REQ-016 Source priority SHALL be exception > jump > branch_taken > sequential.
REQ-017 pc_sel SHALL be combinational and SHALL equal the index of the source loaded into pc at the next edge; it SHALL be 0 when pc holds.
REQ-018 In RUN:
- redirect: pc <= target, flush=1, next state BUBBLE.
- else stall: pc holds, next state STALL.
- else: pc <= pc+4.
REQ-019 In STALL:
- pc holds and fetch_valid=0.
- branch_taken or jump SHALL be captured into a one-entry pending register (target and source), with jump overwriting branch.
- deassertion of stall with a pending entry: pc <= pending target, pc_sel = pending source, flush=1, next state BUBBLE, pending cleared.
- deassertion of stall without a pending entry: pc <= pc+4, next state RUN.
REQ-020 In BUBBLE (one cycle):
- branch_taken and jump SHALL be ignored (wrong-path).
- stall SHALL move to STALL with pc held.
- otherwise pc <= pc+4 and next state RUN.
REQ-021 exception SHALL redirect immediately in any state, overriding stall and discarding any pending entry (with EXC_EN).
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-023 Target bits [1:0] SHALL be forced to 0 when loaded into pc.
REQ-024 fetch_valid SHALL be 1 in RUN and BUBBLE, and 0 in STALL and during reset.

Reset
REQ-025 On reset:
- pc <= RESET_PC, state <= RUN, pending cleared.
- flush=0, fetch_valid=0, pc_sel=0 for the reset cycle.
REQ-026 Reset SHALL override every other input, including mid-stall with a pending redirect; the pending target SHALL be discarded.

Configuration
REQ-027 Macro PC_FETCH_CTRL_EXC_EN defined: exception behaves per REQ-016/REQ-021, and pc_sel=3 loads EXC_VECTOR.
REQ-028 Macro PC_FETCH_CTRL_EXC_EN undefined: exception SHALL be ignored, pc_sel SHALL never equal 3, and EXC_VECTOR is unused.

Verification
REQ-029 Reset, then 4 free-running cycles -> pc = 0, 4, 8, 12; pc_sel=0; fetch_valid=1 after reset.
REQ-030 At pc=8, branch_taken=1 with branch_target=32'h100 -> same cycle pc_sel=1, flush=1; next pc=32'h100 in BUBBLE; then 32'h104.
REQ-031 stall for 3 cycles at pc=16 with jump to 32'h200 in the second stall cycle -> pc holds 16, fetch_valid=0; after release pc_sel=2, flush=1, next pc=32'h200.
REQ-032 In BUBBLE, branch_taken to 32'h300 -> ignored, pc advances by 4; in the same scenario with exception (EXC_EN defined) and stall=1 -> pc=32'h80000180.
REQ-033 pc=32'hFFFFFFFC, no requests -> next pc=32'h00000000; jump_target=32'h203 -> pc=32'h200.
REQ-034 reset asserted in STALL with a pending branch -> pc=RESET_PC, pending discarded, no redirect after release.
